seq_scan_ctrl: RTL and testbench

Word-level controller for the 1011 sequence detector: it accepts parallel words over a valid/ready handshake, serializes each word one bit per clock into an internal overlapping Moore 1011 detector, and returns a per-word match count over a second valid/ready handshake. It sits between a parallel producer (bus or FIFO) and any consumer of match statistics. It replaces hand-driven serial stimulus with a sequenced, back-pressurable stream. Detector history is carried across word boundaries, so matches that straddle two words are counted.

---
 rtl/seq_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word-level controller around an overlapping Moore 1011 detector (optional SEQ_SCAN_TOTAL_EN adds total_count)
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             busy,
    output logic [2:0]       det_state
`ifdef SEQ_SCAN_TOTAL_EN
    ,
    output logic [15:0]      total_count
`endif
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_t;

    ctrl_t            state, state_n;
    det_t             det, det_n, det_step;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] wcnt, wcnt_n;
    logic [CNT_W-1:0] ocnt_n;
    logic             ovalid_n;
    logic             hit;
`ifdef SEQ_SCAN_TOTAL_EN
    logic [15:0]      total, total_n;
`endif

    // One step of the overlapping 1011 recognizer; S4 means a match just completed
    function automatic det_t det_next(input det_t s, input logic x);
        case (s)
            S0:      det_next = x ? S1 : S0;
            S1:      det_next = x ? S1 : S2;
            S2:      det_next = x ? S3 : S0;
            S3:      det_next = x ? S4 : S2;
            S4:      det_next = x ? S1 : S2;
            default: det_next = S0;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            det       <= S0;
            shreg     <= '0;
            idx       <= '0;
            wcnt      <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
`ifdef SEQ_SCAN_TOTAL_EN
            total     <= '0;
`endif
        end else begin
            state     <= state_n;
            det       <= det_n;
            shreg     <= shreg_n;
            idx       <= idx_n;
            wcnt      <= wcnt_n;
            out_count <= ocnt_n;
            out_valid <= ovalid_n;
`ifdef SEQ_SCAN_TOTAL_EN
            total     <= total_n;
`endif
        end
    end

    // Next-state logic; the last shift slot also captures the report so out_count is registered
    always_comb begin
        state_n  = state;
        det_n    = det;
        det_step = det_next(det, shreg[WIDTH-1]);
        shreg_n  = shreg;
        idx_n    = idx;
        wcnt_n   = wcnt;
        ocnt_n   = out_count;
        ovalid_n = out_valid;
        hit      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_n = in_data;
                    idx_n   = IDX_W'(WIDTH - 1);
                    wcnt_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                det_n   = det_step;
                hit     = !clear && (det_step == S4);
                shreg_n = {shreg[WIDTH-2:0], 1'b0};
                idx_n   = idx - 1'b1;
                if (hit && (wcnt != {CNT_W{1'b1}}))
                    wcnt_n = wcnt + 1'b1;
                if (idx == '0) begin
                    state_n  = REPORT;
                    ovalid_n = 1'b1;
                    ocnt_n   = wcnt_n;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_n  = IDLE;
                    ovalid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        // A cleared bit still uses its slot but leaves no history behind
        if (clear)
            det_n = S0;
`ifdef SEQ_SCAN_TOTAL_EN
        if (clear)
            total_n = '0;
        else if (hit)
            total_n = total + 16'd1;
        else
            total_n = total;
`endif
    end

    // Handshake and debug outputs decode registered state only
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        det_state = det;
    end

`ifdef SEQ_SCAN_TOTAL_EN
    assign total_count = total;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized self-checking bench for seq_scan_ctrl against a bit-history model
module tb_seq_scan_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         clear = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, busy;
    logic [3:0]   out_count;
    logic [2:0]   det_state;
    logic         s_in_ready, s_out_valid, s_busy;
    logic [0:0]   s_out_count;
    logic [2:0]   s_det_state;
`ifdef SEQ_SCAN_TOTAL_EN
    logic [15:0]  total_count, s_total_count;
`endif

    seq_scan_ctrl #(.WIDTH(W), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
        .out_count(out_count), .out_ready(out_ready), .busy(busy),
        .det_state(det_state)
`ifdef SEQ_SCAN_TOTAL_EN
        , .total_count(total_count)
`endif
    );

    seq_scan_ctrl #(.WIDTH(W), .CNT_W(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .clear(clear), .out_valid(s_out_valid),
        .out_count(s_out_count), .out_ready(out_ready), .busy(s_busy),
        .det_state(s_det_state)
`ifdef SEQ_SCAN_TOTAL_EN
        , .total_count(s_total_count)
`endif
    );

    always #5 clk = ~clk;

    int total_n = 0;
    int bad_n = 0;

    // reference model: recent bit history since the last clear/reset
    int         hlen = 0;
    logic [3:0] hist = '0;
    int         mcnt = 0;
    int         mtotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        if (obs !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hlen = 0;
        mtotal = 0;
    endtask

    task automatic model_bit(input logic b, input logic clr);
        if (clr) begin
            hlen = 0;
            mtotal = 0;
        end else begin
            hist = {hist[2:0], b};
            if (hlen < 4) hlen++;
            if (hlen == 4 && hist == 4'b1011) begin
                mcnt++;
                mtotal = (mtotal + 1) % 65536;
            end
        end
    endtask

    task automatic idle_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [W-1:0] d, input int clr_slot, input int bp);
        int n;
        logic [3:0] held;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        mcnt = 0;
        @(posedge clk);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            clear    = (k == clr_slot);
            if (k == 0) begin
                chk("busy_shift", busy, 1);
                chk("in_ready_shift", in_ready, 0);
            end
            if (k == W - 1) chk("early_valid", out_valid, 0);
            model_bit(d[W-1-k], clear);
            @(posedge clk);
        end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("out_valid", out_valid, 1);
        chk("out_count", out_count, (mcnt > 15) ? 15 : mcnt);
        chk("sat_count", s_out_count, (mcnt > 1) ? 1 : mcnt);
`ifdef SEQ_SCAN_TOTAL_EN
        chk("total_count", total_count, mtotal);
`endif
        held = out_count;
        if (bp > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = W'($urandom);
            repeat (bp) begin
                @(posedge clk);
                @(negedge clk);
                chk("bp_valid", out_valid, 1);
                chk("bp_count", out_count, held);
                chk("bp_in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_det", det_state, 0);
        chk("rst_count", out_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        send(8'b1011_0110, -1, 0);
        send(8'b0000_0101, -1, 0);
        chk("cross_det", det_state, 3);
        send(8'b1000_0000, -1, 0);

        send(8'b0000_0101, -1, 0);
        idle_clear();
        chk("clear_det", det_state, 0);
        send(8'b1000_0000, -1, 0);

        idle_clear();
        send(8'b1011_1011, -1, 0);
        send(8'b1011_0110, -1, 5);
        send(8'b1101_1011, 2, 0);

        // abort a word partway through SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_det", det_state, 0);
        chk("arst_count", out_count, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_report", out_valid, 0);
        end
        send(8'b1011_0000, -1, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) idle_clear();
            send(W'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
